// File: rtl/alu_mc_if.sv
// ALU_MC bus bundle: operand/control inputs and result/status outputs.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [5:0]       C;
  logic [1:0]       op;
  logic             start;
  logic             en_bar;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] bus;
  logic             Z_flag;
  logic             LT_flag;

  modport master (
    output X, Y, C, op, start, en_bar,
    input  busy, done, val, bus, Z_flag, LT_flag
  );

  modport slave (
    input  X, Y, C, op, start, en_bar,
    output busy, done, val, bus, Z_flag, LT_flag
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle AND/ADD, shift-add multiply,
// one-bit-per-cycle logical right shift.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic  clk,
  input  logic  reset,
  alu_mc_if.slave io
);
  typedef enum logic [1:0] {IDLE, MUL, SHR} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] ONE  = SHW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ax_q, ax_d;
  logic [WIDTH-1:0] ay_q, ay_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             no_q, no_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             z_q, lt_q;
  logic             done_q, done_d;

  logic [WIDTH-1:0] inx, iny, argx, argy;
  logic [WIDTH-1:0] madd, sum, raw;
  logic [SHW-1:0]   n;
  logic             ld, inv;

  assign inx  = io.C[5] ? io.X : '0;
  assign argx = io.C[4] ? ~inx : inx;
  assign iny  = io.C[3] ? io.Y : '0;
  assign argy = io.C[2] ? ~iny : iny;
  assign n    = io.Y[SHW-1:0];
  assign madd = ay_q[0] ? ax_q : '0;
  assign sum  = acc_q + madd;

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    no_d    = no_q;
    val_d   = val_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    inv     = 1'b0;
    raw     = '0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          unique case (io.op)
            2'b01: begin
              ax_d    = argx;
              ay_d    = argy;
              no_d    = io.C[0];
              acc_d   = '0;
              cnt_d   = '0;
              state_d = MUL;
            end
            2'b10: begin
              if (n == '0) begin
                ld  = 1'b1;
                inv = io.C[0];
                raw = argx;
              end else begin
                ax_d    = argx;
                no_d    = io.C[0];
                cnt_d   = n;
                state_d = SHR;
              end
            end
            default: begin
              ld  = 1'b1;
              inv = io.C[0];
              raw = io.C[1] ? argx + argy : argx & argy;
            end
          endcase
        end
      end
      MUL: begin
        acc_d = sum;
        ax_d  = ax_q << 1;
        ay_d  = ay_q >> 1;
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          ld      = 1'b1;
          inv     = no_q;
          raw     = sum;
          state_d = IDLE;
        end
      end
      SHR: begin
        ax_d  = ax_q >> 1;
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          ld      = 1'b1;
          inv     = no_q;
          raw     = ax_q >> 1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      val_d  = inv ? ~raw : raw;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      no_q    <= 1'b0;
      val_q   <= '0;
      z_q     <= 1'b1;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      no_q    <= no_d;
      val_q   <= val_d;
      z_q     <= (val_d == '0);
      lt_q    <= val_d[WIDTH-1];
      done_q  <= done_d;
    end
  end

  assign io.busy    = (state_q != IDLE);
  assign io.done    = done_q;
  assign io.val     = val_q;
  assign io.Z_flag  = z_q;
  assign io.LT_flag = lt_q;
  assign io.bus     = io.en_bar ? '0 : val_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=16.
module tb_alu_mc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) io ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] v;
  } vec_t;

  vec_t vt[9];
  int total = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_res(input string nm, input logic [W-1:0] v);
    chk({nm, " val"}, io.val, v);
    chk({nm, " Z"}, io.Z_flag, (v == 0));
    chk({nm, " LT"}, io.LT_flag, v[W-1]);
  endtask

  task automatic run_single(input string nm, input vec_t t);
    io.op = t.op; io.C = t.c; io.X = t.x; io.Y = t.y;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk({nm, " done"}, io.done, 1'b1);
    chk({nm, " busy"}, io.busy, 1'b0);
    chk_res(nm, t.v);
    @(posedge clk); #1;
    chk({nm, " done drop"}, io.done, 1'b0);
  endtask

  task automatic run_multi(input string nm, input logic [1:0] op,
                           input logic [5:0] c, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] v,
                           input int ncyc);
    int cyc;
    int bad;
    cyc = 0;
    bad = 0;
    io.op = op; io.C = c; io.X = x; io.Y = y;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    io.X = 16'hA5A5; io.Y = 16'h0003; io.C = 6'b111111; io.op = 2'b00;
    while (!io.done && cyc < 100) begin
      if (!io.busy) bad++;
      io.start = (cyc < ncyc - 1) && cyc[0];
      @(posedge clk); #1;
      cyc++;
    end
    io.start = 1'b0;
    chk({nm, " cycles"}, cyc, ncyc);
    chk({nm, " busy gaps"}, bad, 0);
    chk({nm, " done"}, io.done, 1'b1);
    chk({nm, " busy end"}, io.busy, 1'b0);
    chk_res(nm, v);
    @(posedge clk); #1;
    chk({nm, " done drop"}, io.done, 1'b0);
    chk({nm, " hold"}, io.val, v);
  endtask

  initial begin
    int cyc;
    logic saw_done;

    vt[0] = '{2'b00, 6'b101010, 16'd3,     16'd5,     16'd8};
    vt[1] = '{2'b00, 6'b000001, 16'd3,     16'd5,     16'hFFFF};
    vt[2] = '{2'b00, 6'b000000, 16'd3,     16'd5,     16'h0000};
    vt[3] = '{2'b00, 6'b101000, 16'hF0F0,  16'h0FF0,  16'h00F0};
    vt[4] = '{2'b11, 6'b101010, 16'hFFFF,  16'h0001,  16'h0000};
    vt[5] = '{2'b00, 6'b011010, 16'h1234,  16'd5,     16'd4};
    vt[6] = '{2'b00, 6'b111111, 16'd1,     16'd2,     16'd4};
    vt[7] = '{2'b10, 6'b100000, 16'h8000,  16'h0000,  16'h8000};
    vt[8] = '{2'b10, 6'b100001, 16'h1234,  16'h0010,  16'hEDCB};

    reset = 1'b1;
    io.X = '0; io.Y = '0; io.C = '0; io.op = '0;
    io.start = 1'b0; io.en_bar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst val", io.val, 16'h0000);
    chk("rst Z", io.Z_flag, 1'b1);
    chk("rst LT", io.LT_flag, 1'b0);
    chk("rst busy", io.busy, 1'b0);
    chk("rst done", io.done, 1'b0);
    chk("rst bus", io.bus, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_single($sformatf("vec%0d", i), vt[i]);

    run_multi("mul300", 2'b01, 6'b101000, 16'd300, 16'd300, 16'h5F90, 16);
    run_multi("mulinv", 2'b01, 6'b101001, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16);
    run_multi("shr15", 2'b10, 6'b100000, 16'h8000, 16'd15, 16'h0001, 15);
    run_multi("shr4", 2'b10, 6'b110000, 16'h00FF, 16'd4, 16'h0FF0, 4);

    // back-to-back: new start accepted in the done cycle
    io.op = 2'b01; io.C = 6'b101000; io.X = 16'd3; io.Y = 16'd5;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    cyc = 0;
    while (!io.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b mul cycles", cyc, 16);
    chk("b2b mul val", io.val, 16'd15);
    io.op = 2'b00; io.C = 6'b101010; io.X = 16'd1; io.Y = 16'd1;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("b2b add done", io.done, 1'b1);
    chk("b2b add val", io.val, 16'd2);

    // reset mid-multiply
    io.op = 2'b01; io.C = 6'b101000; io.X = 16'd300; io.Y = 16'd300;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort busy pre", io.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort busy", io.busy, 1'b0);
    chk("abort val", io.val, 16'h0000);
    chk("abort Z", io.Z_flag, 1'b1);
    chk("abort done", io.done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    io.op = 2'b00; io.C = 6'b101010; io.X = 16'd3; io.Y = 16'd5;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("post rst done", io.done, 1'b1);
    chk_res("post rst", 16'd8);
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (io.done) saw_done = 1'b1;
    end
    chk("no stale done", saw_done, 1'b0);

    io.en_bar = 1'b0;
    #1;
    chk("bus en", io.bus, 16'd8);
    io.en_bar = 1'b1;
    #1;
    chk("bus dis", io.bus, 16'd0);
    chk("bus val kept", io.val, 16'd8);
    io.en_bar = 1'b0;
    #1;
    chk("bus re-en", io.bus, 16'd8);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
